// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, fetch FSM
// state codes and the sequential PC step.
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives imem req/addr,
// applies redirect/stall and delivers pc/instr/valid to IF/ID.
//
// Ports:
//   clk, rst (async active-low)
//   stall_i, redirect_i, redirect_pc_i    : control from ID/EX
//   imem_req_o, imem_addr_o               : fetch request
//   imem_ready_i, imem_rdata_i            : same-cycle accept + data
//   pc_o, instr_o, valid_o                : IF/ID payload
//   flush_o, misalign_o                   : one-cycle pulses on redirect
//   fetch_cnt_o                           : delivered instruction count
module fetch_ctrl #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic [15:0]     fetch_cnt_o
);

    import rv_pipe_pkg::*;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    logic [1:0]      state;
    logic [3:0]      boot_cnt;
    logic [XLEN-1:0] fetch_pc;

    // Mutually exclusive actions, decoded in priority order
    // redirect > stall > ready.
    logic in_boot;
    logic do_redir;
    logic do_hold;
    logic do_stall;
    logic do_cap;
    logic do_bubble;

    always_comb begin
        in_boot   = (state == ST_BOOT);
        do_redir  = !in_boot && redirect_i;
        do_hold   = !in_boot && !redirect_i && (state == ST_STALL);
        do_stall  = (state == ST_FETCH) && !redirect_i && stall_i;
        do_cap    = (state == ST_FETCH) && !redirect_i && !stall_i
                    && imem_ready_i;
        do_bubble = (state == ST_FETCH) && !redirect_i && !stall_i
                    && !imem_ready_i;
    end

    assign imem_req_o  = (state == ST_FETCH);
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            boot_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            pc_o        <= '0;
            instr_o     <= XLEN'(NOP_INSTR);
            valid_o     <= 1'b0;
            flush_o     <= 1'b0;
            misalign_o  <= 1'b0;
            fetch_cnt_o <= '0;
        end else begin
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
            unique case (1'b1)
                in_boot: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state <= ST_FETCH;
                    end
                end
                do_redir: begin
                    state      <= ST_FETCH;
                    fetch_pc   <= {redirect_pc_i[XLEN-1:2], 2'b00};
                    instr_o    <= XLEN'(NOP_INSTR);
                    valid_o    <= 1'b0;
                    flush_o    <= 1'b1;
                    misalign_o <= |redirect_pc_i[1:0];
                end
                do_hold: begin
                    // Everything stays frozen; leave once stall drops.
                    if (!stall_i) begin
                        state <= ST_FETCH;
                    end
                end
                do_stall: begin
                    state <= ST_STALL;
                end
                do_cap: begin
                    instr_o     <= imem_rdata_i;
                    pc_o        <= fetch_pc;
                    valid_o     <= 1'b1;
                    fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
                    fetch_cnt_o <= fetch_cnt_o + 16'd1;
                end
                do_bubble: begin
                    instr_o <= XLEN'(NOP_INSTR);
                    valid_o <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
